// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//
// Direct-mapped, write-through, no-write-allocate cache with one-word lines,
// placed between a CPU port and a slow handshaked main memory.
//
// Parameters
//   WIDTH  data word width
//   DEPTH  main-memory size in words (AW = log2(DEPTH) address bits)
//   LINES  number of one-word cache lines (IW = log2(LINES) index bits,
//          TW = AW - IW tag bits)
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   cpu_read/write    CPU request, held until stall is low; both high = write
//   cpu_address       word address: index = [IW-1:0], tag = [AW-1:IW]
//   cpu_write_data    store data
//   cpu_read_data     registered load data
//   stall             CPU must hold request and operands while high
//   mem_address       registered main-memory address
//   mem_write_en      level write enable, held until mem_ready
//   mem_read_en       level read enable, held until mem_ready
//   mem_write_data    registered main-memory store data
//   mem_ready         one-cycle completion pulse from main memory
//   mem_read_data     load data, valid the cycle after mem_ready
//   hit_count         saturating read-hit counter
//   miss_count        saturating read-miss counter
// ---------------------------------------------------------------------------
module cache_controller #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int LINES = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int IW = $clog2(LINES),
    localparam int TW = AW - IW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_read,
    input  logic             cpu_write,
    input  logic [AW-1:0]    cpu_address,
    input  logic [WIDTH-1:0] cpu_write_data,
    output logic [WIDTH-1:0] cpu_read_data,
    output logic             stall,
    output logic [AW-1:0]    mem_address,
    output logic             mem_write_en,
    output logic             mem_read_en,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_read_data,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        MEM_WRITE,
        MEM_READ,
        REFILL,
        RESP
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [LINES-1:0] r_valid;
    logic [TW-1:0]    r_tag_mem  [LINES];
    logic [WIDTH-1:0] r_data_mem [LINES];

    logic [IW-1:0]    w_index;
    logic [TW-1:0]    w_tag;
    logic             w_hit;
    logic             w_is_write;
    logic             w_is_read;
    logic [IW-1:0]    w_fill_index;
    logic [TW-1:0]    w_fill_tag;

    assign w_index    = cpu_address[IW-1:0];
    assign w_tag      = cpu_address[AW-1:IW];
    assign w_hit      = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
    // A simultaneous read and write is treated as a write only.
    assign w_is_write = cpu_write;
    assign w_is_read  = cpu_read && !cpu_write;

    // The refill target comes from the latched miss address, not the CPU bus.
    assign w_fill_index = mem_address[IW-1:0];
    assign w_fill_tag   = mem_address[AW-1:IW];

    // ------------------------------------------------------------------
    // Next state and stall
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        stall        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_write) begin
                    stall        = 1'b1;
                    w_next_state = MEM_WRITE;
                end else if (w_is_read && !w_hit) begin
                    stall        = 1'b1;
                    w_next_state = MEM_READ;
                end
            end
            MEM_WRITE: begin
                stall = 1'b1;
                if (mem_ready) w_next_state = RESP;
            end
            MEM_READ: begin
                stall = 1'b1;
                if (mem_ready) w_next_state = REFILL;
            end
            REFILL: begin
                stall        = 1'b1;
                w_next_state = RESP;
            end
            RESP: begin
                // Stall drops for this single cycle so the CPU retires the
                // request; nothing new is accepted until IDLE.
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, valid bits, memory interface and counters
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_valid        <= '0;
            cpu_read_data  <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_write_en   <= 1'b0;
            mem_read_en    <= 1'b0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_is_write) begin
                        mem_address    <= cpu_address;
                        mem_write_data <= cpu_write_data;
                        mem_write_en   <= 1'b1;
                    end else if (w_is_read) begin
                        if (w_hit) begin
                            cpu_read_data <= r_data_mem[w_index];
                            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                        end else begin
                            mem_address <= cpu_address;
                            mem_read_en <= 1'b1;
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                        end
                    end
                end
                MEM_WRITE: begin
                    if (mem_ready) mem_write_en <= 1'b0;
                end
                MEM_READ: begin
                    if (mem_ready) mem_read_en <= 1'b0;
                end
                REFILL: begin
                    r_valid[w_fill_index] <= 1'b1;
                    cpu_read_data         <= mem_read_data;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag and data arrays
    // ------------------------------------------------------------------
    // NOTE: the arrays carry no reset; the valid bits alone decide whether a
    // line holds anything, so clearing storage would only cost logic.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_is_write && w_hit) begin
            r_data_mem[w_index] <= cpu_write_data;
        end else if (r_state == REFILL) begin
            r_data_mem[w_fill_index] <= mem_read_data;
            r_tag_mem[w_fill_index]  <= w_fill_tag;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 1024;
    localparam int LINES   = 32;
    localparam int AW      = 10;
    localparam int MEM_LAT = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cpu_read = 1'b0;
    logic             cpu_write = 1'b0;
    logic [AW-1:0]    cpu_address = '0;
    logic [WIDTH-1:0] cpu_write_data = '0;
    logic [WIDTH-1:0] cpu_read_data;
    logic             stall;
    logic [AW-1:0]    mem_address;
    logic             mem_write_en;
    logic             mem_read_en;
    logic [WIDTH-1:0] mem_write_data;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_read_data;
    logic [15:0]      hit_count;
    logic [15:0]      miss_count;

    always #5 clk = ~clk;

    cache_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LINES(LINES)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .stall          (stall),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_write_data (mem_write_data),
        .mem_ready      (mem_ready),
        .mem_read_data  (mem_read_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    function automatic logic [WIDTH-1:0] init_word(input int a);
        return 32'hC0DE_0000 | WIDTH'(a);
    endfunction

    // ---------------- main memory: ready in the 4th cycle after enable cycles
    logic [WIDTH-1:0] mem_arr [DEPTH];
    bit               mem_loaded = 1'b0;
    int               mem_cnt = 0;

    always @(negedge clk or negedge reset) begin
        if (!mem_loaded) begin
            for (int a = 0; a < DEPTH; a++) mem_arr[a] <= init_word(a);
            mem_loaded <= 1'b1;
        end
        if (!reset) begin
            mem_cnt   <= 0;
            mem_ready <= 1'b0;
        end else if (mem_ready) begin
            mem_ready <= 1'b0;
            mem_cnt   <= 0;
        end else if (mem_read_en || mem_write_en) begin
            if (mem_cnt == MEM_LAT) begin
                mem_ready <= 1'b1;
                if (mem_write_en) mem_arr[mem_address] <= mem_write_data;
                else              mem_read_data <= mem_arr[mem_address];
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    // ---------------- enable monitor (running totals)
    int            wr_en_tot = 0;
    int            rd_en_tot = 0;
    int            both_en_tot = 0;
    logic [AW-1:0] last_en_addr = '0;

    always @(negedge clk) begin
        if (mem_write_en) wr_en_tot <= wr_en_tot + 1;
        if (mem_read_en)  rd_en_tot <= rd_en_tot + 1;
        if (mem_write_en && mem_read_en) both_en_tot <= both_en_tot + 1;
        if (mem_write_en || mem_read_en) last_en_addr <= mem_address;
    end

    // ---------------- checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: cache contents as plain arrays
    bit               ref_valid [LINES];
    int               ref_tag   [LINES];
    logic [WIDTH-1:0] ref_data  [LINES];
    logic [WIDTH-1:0] ref_mem   [DEPTH];
    int               ref_hits;
    int               ref_misses;

    task automatic model_reset();
        for (int l = 0; l < LINES; l++) ref_valid[l] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic model_req(input logic rd, input logic wr, input int addr,
                             input logic [WIDTH-1:0] wd,
                             output logic [WIDTH-1:0] exp_rdata, output int exp_stall);
        int idx;
        int tg;
        idx       = addr % LINES;
        tg        = addr / LINES;
        exp_rdata = '0;
        exp_stall = 0;
        if (wr) begin
            ref_mem[addr] = wd;
            if (ref_valid[idx] && ref_tag[idx] == tg) ref_data[idx] = wd;
            exp_stall = 6;
        end else if (rd) begin
            if (ref_valid[idx] && ref_tag[idx] == tg) begin
                exp_rdata = ref_data[idx];
                exp_stall = 0;
                if (ref_hits < 65535) ref_hits++;
            end else begin
                exp_rdata      = ref_mem[addr];
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
                ref_data[idx]  = ref_mem[addr];
                exp_stall      = 7;
                if (ref_misses < 65535) ref_misses++;
            end
        end
    endtask

    // ---------------- one CPU request, held until stall drops
    task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                          input logic [WIDTH-1:0] wd,
                          output logic [WIDTH-1:0] rdata, output int stall_cyc,
                          output int wr_cyc, output int rd_cyc, output logic [AW-1:0] en_addr);
        int w0;
        int r0;
        @(posedge clk); #1;
        w0             = wr_en_tot;
        r0             = rd_en_tot;
        cpu_read       = rd;
        cpu_write      = wr;
        cpu_address    = addr;
        cpu_write_data = wd;
        stall_cyc      = 0;
        while (1) begin
            @(negedge clk);
            if (!stall) break;
            stall_cyc++;
            if (stall_cyc > 100) begin
                n_checks++;
                n_errors++;
                $display("FAIL stall_timeout: stall still high after %0d cycles, addr %0h", stall_cyc, addr);
                break;
            end
        end
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        rdata     = cpu_read_data;
        wr_cyc    = wr_en_tot - w0;
        rd_cyc    = rd_en_tot - r0;
        en_addr   = last_en_addr;
    endtask

    typedef struct {
        logic             rd;
        logic             wr;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wd;
        bit               chk_rdata;
        logic [WIDTH-1:0] exp_rdata;
        int               exp_stall;
        int               exp_wr_cyc;
        int               exp_rd_cyc;
        int               exp_hits;
        int               exp_misses;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] rdata;
        logic [WIDTH-1:0] exp_rdata;
        logic [AW-1:0]    en_addr;
        int               stall_cyc;
        int               wr_cyc;
        int               rd_cyc;
        int               exp_stall;
        int               op;
        logic             rd;
        logic             wr;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wd;

        for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
        model_reset();

        //         rd    wr    addr     wdata         chk   exp_rdata     stl wr rd h  m
        vecs[0] = '{1'b1, 1'b0, 10'h025, 32'h0,        1'b1, 32'hC0DE0025, 7, 0, 5, 0, 1};
        vecs[1] = '{1'b1, 1'b0, 10'h025, 32'h0,        1'b1, 32'hC0DE0025, 0, 0, 0, 1, 1};
        vecs[2] = '{1'b0, 1'b1, 10'h025, 32'hDEADBEEF, 1'b0, 32'h0,        6, 5, 0, 1, 1};
        vecs[3] = '{1'b1, 1'b0, 10'h025, 32'h0,        1'b1, 32'hDEADBEEF, 0, 0, 0, 2, 1};
        vecs[4] = '{1'b0, 1'b1, 10'h045, 32'h12345678, 1'b0, 32'h0,        6, 5, 0, 2, 1};
        vecs[5] = '{1'b1, 1'b0, 10'h025, 32'h0,        1'b1, 32'hDEADBEEF, 0, 0, 0, 3, 1};
        vecs[6] = '{1'b1, 1'b0, 10'h045, 32'h0,        1'b1, 32'h12345678, 7, 0, 5, 3, 2};
        vecs[7] = '{1'b1, 1'b0, 10'h025, 32'h0,        1'b1, 32'hDEADBEEF, 7, 0, 5, 3, 3};
        vecs[8] = '{1'b1, 1'b1, 10'h010, 32'h0000AAAA, 1'b0, 32'h0,        6, 5, 0, 3, 3};
        vecs[9] = '{1'b1, 1'b0, 10'h010, 32'h0,        1'b1, 32'h0000AAAA, 7, 0, 5, 3, 4};

        // ---------------- reset state
        repeat (2) @(negedge clk);
        check("rst_stall",      stall,          1'b0);
        check("rst_mem_we",     mem_write_en,   1'b0);
        check("rst_mem_re",     mem_read_en,    1'b0);
        check("rst_mem_addr",   mem_address,    '0);
        check("rst_mem_wdata",  mem_write_data, '0);
        check("rst_rdata",      cpu_read_data,  '0);
        check("rst_hits",       hit_count,      16'd0);
        check("rst_misses",     miss_count,     16'd0);
        reset = 1'b1;

        // ---------------- directed table
        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                   rdata, stall_cyc, wr_cyc, rd_cyc, en_addr);
            model_req(vecs[i].rd, vecs[i].wr, int'(vecs[i].addr), vecs[i].wd, exp_rdata, exp_stall);
            check($sformatf("vec%0d_stall", i),  stall_cyc,  vecs[i].exp_stall);
            check($sformatf("vec%0d_wr_en", i),  wr_cyc,     vecs[i].exp_wr_cyc);
            check($sformatf("vec%0d_rd_en", i),  rd_cyc,     vecs[i].exp_rd_cyc);
            check($sformatf("vec%0d_hits", i),   hit_count,  vecs[i].exp_hits);
            check($sformatf("vec%0d_misses", i), miss_count, vecs[i].exp_misses);
            if (vecs[i].chk_rdata)
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_wr_cyc + vecs[i].exp_rd_cyc > 0)
                check($sformatf("vec%0d_mem_addr", i), en_addr, vecs[i].addr);
        end
        check("mem_0x045_written", mem_arr[10'h045], 32'h12345678);

        // ---------------- reset during MEM_READ
        @(posedge clk); #1;
        cpu_read    = 1'b1;
        cpu_address = 10'h0B7;
        repeat (3) @(negedge clk);
        check("midrst_rd_en_before", mem_read_en, 1'b1);
        #2;
        reset    = 1'b0;
        cpu_read = 1'b0;
        #1;
        check("midrst_rd_en",  mem_read_en,  1'b0);
        check("midrst_wr_en",  mem_write_en, 1'b0);
        check("midrst_stall",  stall,        1'b0);
        check("midrst_hits",   hit_count,    16'd0);
        check("midrst_misses", miss_count,   16'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_req(1'b1, 1'b0, 10'h025, '0, rdata, stall_cyc, wr_cyc, rd_cyc, en_addr);
        model_req(1'b1, 1'b0, 'h025, '0, exp_rdata, exp_stall);
        check("postrst_025_stall", stall_cyc, exp_stall);
        check("postrst_025_rdata", rdata,     exp_rdata);
        do_req(1'b1, 1'b0, 10'h0B7, '0, rdata, stall_cyc, wr_cyc, rd_cyc, en_addr);
        model_req(1'b1, 1'b0, 'h0B7, '0, exp_rdata, exp_stall);
        check("postrst_0b7_stall", stall_cyc, exp_stall);
        check("postrst_0b7_rdata", rdata,     exp_rdata);

        // ---------------- randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            op   = int'($urandom_range(0, 9));
            rd   = (op <= 5) || (op == 9);
            wr   = (op >= 6);
            addr = AW'($urandom_range(0, 3) * LINES + $urandom_range(0, 7));
            wd   = $urandom;
            do_req(rd, wr, addr, wd, rdata, stall_cyc, wr_cyc, rd_cyc, en_addr);
            model_req(rd, wr, int'(addr), wd, exp_rdata, exp_stall);
            check($sformatf("rnd%0d_stall", i),  stall_cyc,  exp_stall);
            check($sformatf("rnd%0d_hits", i),   hit_count,  ref_hits);
            check($sformatf("rnd%0d_misses", i), miss_count, ref_misses);
            if (!wr)
                check($sformatf("rnd%0d_rdata", i), rdata, exp_rdata);
        end

        // ---------------- hit counter saturation
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        do_req(1'b1, 1'b0, 10'h001, '0, rdata, stall_cyc, wr_cyc, rd_cyc, en_addr);
        model_req(1'b1, 1'b0, 'h001, '0, exp_rdata, exp_stall);
        check("sat_first_miss", miss_count, ref_misses);
        @(posedge clk); #1;
        cpu_read    = 1'b1;
        cpu_address = 10'h001;
        repeat (100) @(posedge clk);
        #1;
        check("sat_hits_100", hit_count, 16'd100);
        repeat (65500) @(posedge clk);
        #1;
        cpu_read = 1'b0;
        check("sat_hits_max",    hit_count,  16'hFFFF);
        check("sat_misses_kept", miss_count, 16'd1);

        check("never_both_enables", both_en_tot, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
